fibo_arbiter: RTL and testbench
===============================

Name: fibo_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one iterative Fibonacci engine (fibonacci2) among N_REQ requesters.
- Accepts a request, launches the engine, and waits for the engine's completion flag.
- Returns the result with a requester ID, overflow flag and error flag over a single valid/ready response channel.
- Sits between client blocks and the engine instance; the engine shares this block's clk and reset_n.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- N_W, 5, width of the Fibonacci index n.
- R_W, 16, result width.
- MAX_N, 24, largest n whose result fits in R_W bits.
- TMO, 40, engine-wait watchdog limit in cycles.

Ports:
- clk, input, 1, clock.
- reset_n, input, 1, asynchronous active-low reset.
- req_valid, input, N_REQ, per-requester request valid.
- req_n, input, N_REQ*N_W, packed per-requester index n; requester i uses bits [i*N_W +: N_W].
- req_ready, output, N_REQ, one-hot accept.
- rsp_valid, output, 1, response valid.
- rsp_ready, input, 1, response consumed.
- rsp_id, output, clog2(N_REQ), requester that owns the response.
- rsp_data, output, R_W, fib(n), with fib(0)=0 and fib(1)=fib(2)=1; truncated mod 2^R_W.
- rsp_ovf, output, 1, set when n > MAX_N.
- rsp_err, output, 1, set on engine watchdog timeout.
- eng_begin, output, 1, engine start pulse.
- eng_n, output, N_W, engine input_s.
- eng_result, input, R_W, engine fibo_out.
- eng_done, input, 1, engine done.
- busy, output, 1, high whenever state != IDLE.

Behaviour:
- Reset values: state=IDLE, rr_ptr=N_REQ-1 (so requester 0 wins first), req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_ovf=0, rsp_err=0, eng_begin=0, eng_n=0, busy=0.
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - If any req_valid is high, the grant g is the first asserted requester searching from rr_ptr+1 with wrap-around.
  - req_ready[g]=1 combinationally in that same cycle; all other req_ready bits are 0.
  - On the edge: latch n=req_n[g], id=g, ovf=(n>MAX_N), err=0.
  - n==0: go to RESP with data=0; the engine is not started.
  - n!=0: go to LAUNCH.
  - req_ready is never asserted outside IDLE. Requesters hold req_valid and req_n stable until accepted.
- LAUNCH: eng_begin=1 and eng_n=latched n for exactly one cycle, then WAIT. eng_done is ignored here because it still reflects the previous run.
- WAIT:
  - Watchdog counter starts at 0 and increments each cycle.
  - eng_done=1: capture eng_result into rsp_data, go to RESP.
  - Counter reaches TMO with no done: rsp_data=0, err=1, go to RESP.
  - WAIT lasts exactly n cycles for a healthy engine.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data, rsp_ovf and rsp_err stay stable until rsp_ready.
  - On the rsp_valid&rsp_ready edge: rr_ptr=id, go to IDLE. No new grant is issued in the handshake cycle.
- Latency: accept at cycle t; first rsp_valid at t+2+n for n>=1, or at t+1 for n=0.
- Minimum turnaround: next accept can occur one cycle after the response handshake.
- Overflow: the engine result is passed through mod 2^R_W; rsp_ovf flags n>MAX_N (25..31 for the defaults).
- Simultaneous requests: round-robin fairness. A requester that keeps req_valid high waits at most N_REQ-1 other transactions.
- A req_valid that drops before acceptance is legal; it is simply not granted.
- Reset mid-operation: all state returns to reset values immediately, any in-flight transaction is lost, and the engine is reset by the same reset_n.

Decomposition:
- Package fibo_pkg:
  - state enum type: IDLE, LAUNCH, WAIT, RESP.
  - Constants FIB_N_W=5, FIB_R_W=16, FIB_MAX_N=24, FIB_TMO=40.
- Sub-module fibo_rr_pick: combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, index, any.
  - Instantiated once.

Test Plan:
- Single request, req 0 with n=10: req_ready[0] pulses once; rsp after 12 cycles with data=55, id=0, ovf=0, err=0.
- n=1 and n=0 on requester 2: data=1 with 3-cycle latency; data=0 with 1-cycle latency and eng_begin never asserted.
- All four requesters valid, n=5: grants in order 0,1,2,3,0; every response has data=5 and the matching id.
- n=25: data=75025 mod 65536=9489, ovf=1. n=24: data=46368, ovf=0.
- Hold rsp_ready=0 for 7 cycles: rsp fields stable, no new req_ready, busy=1 throughout; release gives one handshake, then IDLE.
- Stuck-low eng_done model: err=1 and data=0 after TMO wait cycles. Also assert reset_n mid-WAIT: all outputs return to reset values and the next request then completes normally.

Source files
------------

// File: rtl/fibo_pkg.sv
// Shared types and default sizing for the Fibonacci engine arbiter.
package fibo_pkg;

    localparam int FIB_N_W   = 5;
    localparam int FIB_R_W   = 16;
    localparam int FIB_MAX_N = 24;
    localparam int FIB_TMO   = 40;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP
    } fibo_state_e;

    // Requester ID width; never below one bit so the ID port always exists.
    function automatic int id_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

endpackage

// File: rtl/fibo_arbiter_if.sv
// Request/response bundle between the client blocks and the Fibonacci arbiter.
interface fibo_arbiter_if
    import fibo_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int N_W   = FIB_N_W,
    parameter int R_W   = FIB_R_W
);

    localparam int ID_W = id_width(N_REQ);

    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ*N_W-1:0] req_n;
    logic [N_REQ-1:0]     req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [R_W-1:0]       rsp_data;
    logic                 rsp_ovf;
    logic                 rsp_err;

    modport master (
        output req_valid, req_n, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf, rsp_err
    );

    modport slave (
        input  req_valid, req_n, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf, rsp_err
    );

endinterface

// File: rtl/fibo_rr_pick.sv
// Combinational round-robin picker: first asserted request after ptr, wrapping.
module fibo_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // Offset N_REQ wraps back onto ptr itself, so it is checked last.
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                idx      = ID_W'(j);
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fibo_arbiter.sv
// Shares one iterative Fibonacci engine among N_REQ requesters with
// round-robin grants, an engine watchdog and a single response channel.
module fibo_arbiter
    import fibo_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int N_W   = FIB_N_W,
    parameter int R_W   = FIB_R_W,
    parameter int MAX_N = FIB_MAX_N,
    parameter int TMO   = FIB_TMO
) (
    input  logic           clk,
    input  logic           reset_n,
    fibo_arbiter_if.slave  bus,
    output logic           eng_begin,
    output logic [N_W-1:0] eng_n,
    input  logic [R_W-1:0] eng_result,
    input  logic           eng_done,
    output logic           busy
);

    localparam int ID_W  = id_width(N_REQ);
    localparam int WDG_W = $clog2(TMO + 1);
    localparam logic [N_W-1:0]   MAX_N_V  = N_W'(MAX_N);
    localparam logic [WDG_W-1:0] WDG_LAST = WDG_W'(TMO - 1);

    fibo_state_e      state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [N_W-1:0]   n_q, n_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic [R_W-1:0]   data_q, data_d;
    logic [WDG_W-1:0] wdg_q, wdg_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             eng_begin_q, eng_begin_d;
    logic [N_W-1:0]   eng_n_q, eng_n_d;
    logic             busy_q, busy_d;

    logic [N_REQ-1:0] pick_grant;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;
    logic [N_W-1:0]   sel_n;

    fibo_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Grants are only visible while idle, so a pending request never
    // sees ready during launch, wait or an outstanding response.
    assign bus.req_ready = (state_q == IDLE) ? pick_grant : '0;

    always_comb begin
        sel_n = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_n = bus.req_n[i*N_W +: N_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        n_d      = n_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        data_d   = data_q;
        wdg_d    = wdg_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    id_d    = pick_idx;
                    n_d     = sel_n;
                    ovf_d   = (sel_n > MAX_N_V);
                    err_d   = 1'b0;
                    data_d  = '0;
                    state_d = (sel_n == '0) ? RESP : LAUNCH;
                end
            end
            LAUNCH: begin
                wdg_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                wdg_d = wdg_q + WDG_W'(1);
                if (eng_done) begin
                    data_d  = eng_result;
                    state_d = RESP;
                end else if (wdg_q == WDG_LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rr_ptr_d = id_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered views of the next state.
        rsp_valid_d = (state_d == RESP);
        eng_begin_d = (state_d == LAUNCH);
        eng_n_d     = (state_d == LAUNCH) ? n_d : '0;
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= ID_W'(N_REQ - 1);
            id_q        <= '0;
            n_q         <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            data_q      <= '0;
            wdg_q       <= '0;
            rsp_valid_q <= 1'b0;
            eng_begin_q <= 1'b0;
            eng_n_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            n_q         <= n_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            data_q      <= data_d;
            wdg_q       <= wdg_d;
            rsp_valid_q <= rsp_valid_d;
            eng_begin_q <= eng_begin_d;
            eng_n_q     <= eng_n_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_ovf   = ovf_q;
    assign bus.rsp_err   = err_q;
    assign eng_begin     = eng_begin_q;
    assign eng_n         = eng_n_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_fibo_arbiter.sv
// Directed bench for fibo_arbiter with a behavioural Fibonacci engine model.
module tb_fibo_arbiter;

    localparam int N_REQ = 4;
    localparam int N_W   = 5;
    localparam int R_W   = 16;
    localparam int TMO   = 40;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fibo_arbiter_if #(.N_REQ(N_REQ), .N_W(N_W), .R_W(R_W)) arb_if ();

    logic           eng_begin;
    logic [N_W-1:0] eng_n;
    logic [R_W-1:0] eng_result;
    logic           eng_done;
    logic           busy;

    fibo_arbiter #(
        .N_REQ (N_REQ),
        .N_W   (N_W),
        .R_W   (R_W),
        .MAX_N (24),
        .TMO   (TMO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (arb_if),
        .eng_begin  (eng_begin),
        .eng_n      (eng_n),
        .eng_result (eng_result),
        .eng_done   (eng_done),
        .busy       (busy)
    );

    // Engine model: done in the n-th cycle after the start pulse, then held.
    logic [N_W-1:0] rem;
    logic           hold;
    logic           stuck;
    logic [R_W-1:0] res;

    function automatic logic [R_W-1:0] fib_ref(input logic [N_W-1:0] n);
        logic [R_W-1:0] a, b, t;
        a = '0;
        b = 16'd1;
        for (int i = 0; i < int'(n); i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem  <= '0;
            hold <= 1'b0;
            res  <= '0;
        end else if (eng_begin) begin
            rem  <= eng_n;
            hold <= 1'b0;
            res  <= fib_ref(eng_n);
        end else if (rem != '0) begin
            rem <= rem - 5'd1;
            if (rem == 5'd1) hold <= 1'b1;
        end
    end

    assign eng_done   = ~stuck & ((rem == 5'd1) | hold);
    assign eng_result = res;

    int ready_cnt [N_REQ];
    int begin_cnt = 0;
    always @(negedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_if.req_ready[i]) ready_cnt[i] <= ready_cnt[i] + 1;
        end
        if (eng_begin) begin_cnt <= begin_cnt + 1;
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (arb_if.rsp_valid !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic set_req(input int id, input logic [N_W-1:0] n);
        arb_if.req_n[id*N_W +: N_W] = n;
        arb_if.req_valid[id]        = 1'b1;
    endtask

    task automatic take_rsp(input string tag);
        arb_if.rsp_ready = 1'b1;
        step();
        arb_if.rsp_ready = 1'b0;
        chk({tag, "_rsp_done"}, 32'(arb_if.rsp_valid), 0);
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    task automatic run_one(input string tag, input int id, input logic [N_W-1:0] n,
                           input int exp_lat, input int exp_data,
                           input logic exp_ovf, input logic exp_err);
        int lat;
        set_req(id, n);
        #1;
        chk({tag, "_grant"}, 32'(arb_if.req_ready), 32'(1 << id));
        step();
        arb_if.req_valid[id] = 1'b0;
        wait_rsp(lat);
        $display("txn %s: id=%0d n=%0d lat=%0d data=%0d ovf=%0d err=%0d", tag,
                 arb_if.rsp_id, n, lat, arb_if.rsp_data, arb_if.rsp_ovf, arb_if.rsp_err);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_id"}, 32'(arb_if.rsp_id), 32'(id));
        chk({tag, "_data"}, 32'(arb_if.rsp_data), 32'(exp_data));
        chk({tag, "_ovf"}, 32'(arb_if.rsp_ovf), 32'(exp_ovf));
        chk({tag, "_err"}, 32'(arb_if.rsp_err), 32'(exp_err));
        take_rsp(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int b0;
        reset_n          = 1'b0;
        stuck            = 1'b0;
        arb_if.req_valid = '0;
        arb_if.req_n     = '0;
        arb_if.rsp_ready = 1'b0;
        repeat (3) step();

        // Reset values
        chk("rst_ready", 32'(arb_if.req_ready), 0);
        chk("rst_rsp_valid", 32'(arb_if.rsp_valid), 0);
        chk("rst_id", 32'(arb_if.rsp_id), 0);
        chk("rst_data", 32'(arb_if.rsp_data), 0);
        chk("rst_ovf_err", 32'({arb_if.rsp_ovf, arb_if.rsp_err}), 0);
        chk("rst_eng", 32'({eng_begin, eng_n}), 0);
        chk("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        step();

        // Single request, requester 0, n=10
        set_req(0, 5'd10);
        #1;
        chk("t1_grant", 32'(arb_if.req_ready), 1);
        step();
        arb_if.req_valid[0] = 1'b0;
        chk("t1_begin", 32'(eng_begin), 1);
        chk("t1_eng_n", 32'(eng_n), 10);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_no_ready", 32'(arb_if.req_ready), 0);
        step();
        chk("t1_begin_one_cycle", 32'(eng_begin), 0);
        wait_rsp(lat);
        $display("txn t1: id=%0d lat=%0d data=%0d", arb_if.rsp_id, lat + 1, arb_if.rsp_data);
        chk("t1_lat", 32'(lat + 1), 12);
        chk("t1_data", 32'(arb_if.rsp_data), 55);
        chk("t1_id", 32'(arb_if.rsp_id), 0);
        chk("t1_ovf_err", 32'({arb_if.rsp_ovf, arb_if.rsp_err}), 0);
        chk("t1_ready_pulses", 32'(ready_cnt[0]), 1);
        take_rsp("t1");

        // n=1 and n=0 on requester 2
        run_one("n1", 2, 5'd1, 3, 1, 1'b0, 1'b0);
        b0 = begin_cnt;
        run_one("n0", 2, 5'd0, 1, 0, 1'b0, 1'b0);
        chk("n0_no_begin", 32'(begin_cnt), 32'(b0));

        // Move the pointer to 3 so the contention round starts at 0
        run_one("r3", 3, 5'd0, 1, 0, 1'b0, 1'b0);

        // All four requesters contend with n=5
        for (int i = 0; i < N_REQ; i++) arb_if.req_n[i*N_W +: N_W] = 5'd5;
        arb_if.req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            int exp_id;
            exp_id = k % N_REQ;
            chk("rr_grant", 32'(arb_if.req_ready), 32'(1 << exp_id));
            step();
            if (k == 4) arb_if.req_valid = '0;
            wait_rsp(lat);
            $display("txn rr%0d: id=%0d lat=%0d data=%0d", k, arb_if.rsp_id, lat, arb_if.rsp_data);
            chk("rr_lat", 32'(lat), 7);
            chk("rr_id", 32'(arb_if.rsp_id), 32'(exp_id));
            chk("rr_data", 32'(arb_if.rsp_data), 5);
            chk("rr_no_grant_in_resp", 32'(arb_if.req_ready), 0);
            take_rsp("rr");
        end

        // Overflow boundary
        run_one("n25", 1, 5'd25, 27, 9489, 1'b1, 1'b0);
        run_one("n24", 1, 5'd24, 26, 46368, 1'b0, 1'b0);

        // Back-pressure: response held for 7 cycles with another request pending
        set_req(0, 5'd3);
        #1;
        chk("bp_grant", 32'(arb_if.req_ready), 1);
        step();
        arb_if.req_valid[0] = 1'b0;
        wait_rsp(lat);
        chk("bp_lat", 32'(lat), 5);
        set_req(1, 5'd9);
        for (int c = 0; c < 7; c++) begin
            #1;
            chk("bp_valid", 32'(arb_if.rsp_valid), 1);
            chk("bp_data", 32'(arb_if.rsp_data), 2);
            chk("bp_id", 32'(arb_if.rsp_id), 0);
            chk("bp_busy", 32'(busy), 1);
            chk("bp_no_ready", 32'(arb_if.req_ready), 0);
            step();
        end
        $display("txn bp: id=%0d data=%0d held 7 cycles", arb_if.rsp_id, arb_if.rsp_data);
        take_rsp("bp");
        chk("bp_next_grant", 32'(arb_if.req_ready), 2);
        arb_if.req_valid[1] = 1'b0;
        step();
        chk("drop_not_granted", 32'(busy), 0);
        chk("drop_no_begin", 32'(eng_begin), 0);

        // Watchdog timeout on a stuck engine
        stuck = 1'b1;
        run_one("tmo", 2, 5'd7, TMO + 2, 0, 1'b0, 1'b1);
        stuck = 1'b0;

        // Reset during WAIT
        set_req(0, 5'd20);
        #1;
        step();
        arb_if.req_valid[0] = 1'b0;
        repeat (5) step();
        chk("mid_busy_before", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 0);
        chk("mid_rsp_valid", 32'(arb_if.rsp_valid), 0);
        chk("mid_eng", 32'({eng_begin, eng_n}), 0);
        chk("mid_rsp_fields", 32'({arb_if.rsp_id, arb_if.rsp_data, arb_if.rsp_err}), 0);
        step();
        reset_n = 1'b1;
        step();
        set_req(2, 5'd6);
        set_req(3, 5'd6);
        #1;
        chk("post_rst_grant", 32'(arb_if.req_ready), 4);
        step();
        arb_if.req_valid = '0;
        wait_rsp(lat);
        $display("txn post_rst: id=%0d lat=%0d data=%0d", arb_if.rsp_id, lat, arb_if.rsp_data);
        chk("post_rst_lat", 32'(lat), 8);
        chk("post_rst_data", 32'(arb_if.rsp_data), 8);
        chk("post_rst_id", 32'(arb_if.rsp_id), 2);
        take_rsp("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
